// File: rtl/ascon_pack.sv
// Shared ASCON definitions: state type, constants, FSM state enum and round primitives.
// Latency: none, the round primitives are pure combinational functions.
// Backpressure: not applicable.
package ascon_pack;

  localparam int NB_ROUNDS_A = 12;
  localparam int NB_ROUNDS_B = 8;

  localparam logic [63:0] IV_G  = 64'h80800C0800000000;
  localparam logic [63:0] PAD_G = 64'h8000000000000000;

  // First round index of each permutation flavour; every flavour ends on round 11.
  localparam logic [3:0] ROUND_A_FIRST = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] ROUND_B_FIRST = 4'(12 - NB_ROUNDS_B);
  localparam logic [3:0] ROUND_LAST    = 4'd11;

  // x0 occupies the top 64 bits, so {IV, key, nonce} maps directly onto x0..x4.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_AD, ST_WAIT_C, ST_DATA, ST_FINAL, ST_DONE
  } type_dec_state;

  // Mask folded into the round output on the last round of a phase.
  typedef enum logic [1:0] {
    XOR_NONE, XOR_INIT, XOR_AD, XOR_FINAL
  } type_xor_sel;

  function automatic logic [63:0] rotr(logic [63:0] v, int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic type_state constante_add(type_state s, logic [3:0] r);
    type_state o;
    o = s;
    o.x2[7:0] = s.x2[7:0] ^ {4'hf - r, r};
    return o;
  endfunction

  // Bit-sliced 5-bit S-box applied to all 64 columns at once.
  function automatic type_state substitution(type_state s);
    type_state o;
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s.x0 ^ s.x4;
    x1 = s.x1;
    x2 = s.x2 ^ s.x1;
    x3 = s.x3;
    x4 = s.x4 ^ s.x3;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    o.x0 = x0;
    o.x1 = x1;
    o.x2 = x2;
    o.x3 = x3;
    o.x4 = x4;
    return o;
  endfunction

  function automatic type_state diffusion(type_state s);
    type_state o;
    o.x0 = s.x0 ^ rotr(s.x0, 19) ^ rotr(s.x0, 28);
    o.x1 = s.x1 ^ rotr(s.x1, 61) ^ rotr(s.x1, 39);
    o.x2 = s.x2 ^ rotr(s.x2, 1)  ^ rotr(s.x2, 6);
    o.x3 = s.x3 ^ rotr(s.x3, 10) ^ rotr(s.x3, 17);
    o.x4 = s.x4 ^ rotr(s.x4, 7)  ^ rotr(s.x4, 41);
    return o;
  endfunction

endpackage

// File: rtl/ascon_decrypt_fsm.sv
// Sequencer for ASCON-128a decryption: phase FSM, round counter and datapath selects.
// Latency: 21 cycles start to first ready, 9 cycles per block, 13 cycles last DATA to done.
// Backpressure: cipher_ready_o only in WAIT_C; the FSM waits there indefinitely without valid.
module fsm_decrypt
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       cipher_valid_i,
  input  logic       cipher_last_i,
  output logic [3:0] round_o,
  output logic       load_o,
  output logic       run_o,
  output logic       absorb_o,
  output logic       check_o,
  output logic [1:0] xor_sel_o,
  output logic       cipher_ready_o,
  output logic       plain_valid_o,
  output logic       done_o,
  output logic       busy_o
);

  type_dec_state state_q, state_d;
  logic [3:0]    cnt_q, cnt_d, cnt_inc;
  logic          last_q, last_d;

  // Counter parks on the phase end value instead of wrapping.
  assign cnt_inc = (cnt_q == ROUND_LAST) ? cnt_q : cnt_q + 4'd1;
  assign round_o = cnt_q;

  // State, round counter and last-block flag registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and datapath controls.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    load_o         = 1'b0;
    run_o          = 1'b0;
    absorb_o       = 1'b0;
    check_o        = 1'b0;
    xor_sel_o      = XOR_NONE;
    cipher_ready_o = 1'b0;
    plain_valid_o  = 1'b0;
    done_o         = 1'b0;
    busy_o         = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = ROUND_A_FIRST;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        run_o = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_q == ROUND_LAST) begin
          xor_sel_o = XOR_INIT;
          cnt_d     = ROUND_B_FIRST;
          state_d   = ST_AD;
        end
      end
      ST_AD: begin
        run_o = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_q == ROUND_LAST) begin
          xor_sel_o = XOR_AD;
          cnt_d     = ROUND_B_FIRST;
          state_d   = ST_WAIT_C;
        end
      end
      ST_WAIT_C: begin
        cipher_ready_o = 1'b1;
        if (cipher_valid_i) begin
          absorb_o = 1'b1;
          last_d   = cipher_last_i;
          cnt_d    = ROUND_B_FIRST;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        run_o         = 1'b1;
        cnt_d         = cnt_inc;
        plain_valid_o = (cnt_q == ROUND_B_FIRST);
        if (cnt_q == ROUND_LAST) begin
          if (last_q) begin
            xor_sel_o = XOR_FINAL;
            cnt_d     = ROUND_A_FIRST;
            state_d   = ST_FINAL;
          end else begin
            cnt_d   = ROUND_B_FIRST;
            state_d = ST_WAIT_C;
          end
        end
      end
      ST_FINAL: begin
        run_o = 1'b1;
        cnt_d = cnt_inc;
        if (cnt_q == ROUND_LAST) begin
          check_o = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/ascon_decrypt.sv
// ASCON-128a authenticated decryption, one permutation round per cycle (optional tag_o via ASCON_DEC_TAG_OUT_EN).
// Latency: 21 cycles start to first ready, 9 cycles per block, done_o 13 cycles after last DATA round.
// Backpressure: blocks accepted only while cipher_ready_o is high; plaintext output cannot be stalled.
module ascon_decrypt
  import ascon_pack::*;
(
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] ad_i,
  input  logic         cipher_valid_i,
  input  logic [127:0] cipher_i,
  input  logic         cipher_last_i,
  output logic         cipher_ready_o,
  input  logic [127:0] tag_i,
  output logic         plain_valid_o,
  output logic [127:0] plain_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         tag_ok_o
`ifdef ASCON_DEC_TAG_OUT_EN
  ,
  output logic [127:0] tag_o
`endif
);

  logic [3:0]   round_i;
  logic         load, run, absorb, check;
  logic [1:0]   xor_sel;
  type_state    s_q, round_out, xor_mask;
  logic [127:0] tag_calc;

  fsm_decrypt u_fsm (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .cipher_valid_i (cipher_valid_i),
    .cipher_last_i  (cipher_last_i),
    .round_o        (round_i),
    .load_o         (load),
    .run_o          (run),
    .absorb_o       (absorb),
    .check_o        (check),
    .xor_sel_o      (xor_sel),
    .cipher_ready_o (cipher_ready_o),
    .plain_valid_o  (plain_valid_o),
    .done_o         (done_o),
    .busy_o         (busy_o)
  );

  assign round_out = diffusion(substitution(constante_add(s_q, round_i)));

  // Phase-boundary injections; the AD block rides along with the init key mask since XOR commutes.
  always_comb begin
    xor_mask = '0;
    case (xor_sel)
      XOR_INIT:  xor_mask = {ad_i, 64'h0, key_i};
      XOR_AD:    xor_mask = {256'h0, 64'h1};
      XOR_FINAL: xor_mask = {PAD_G, 64'h0, key_i, 64'h0};
      default:   xor_mask = '0;
    endcase
  end

  assign tag_calc = {round_out.x3, round_out.x4} ^ key_i;

  // Permutation state, plaintext and verdict registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s_q      <= '0;
      plain_o  <= '0;
      tag_ok_o <= 1'b0;
    end else begin
      if (load) begin
        s_q <= {IV_G, key_i, nonce_i};
      end else if (absorb) begin
        // Decryption overwrites the rate with the ciphertext rather than XORing it in.
        s_q.x0  <= cipher_i[127:64];
        s_q.x1  <= cipher_i[63:0];
        plain_o <= cipher_i ^ {s_q.x0, s_q.x1};
      end else if (run) begin
        s_q <= type_state'(round_out ^ xor_mask);
      end
      if (load) begin
        tag_ok_o <= 1'b0;
      end else if (check) begin
        tag_ok_o <= (tag_calc == tag_i);
      end
    end
  end

`ifdef ASCON_DEC_TAG_OUT_EN
  // Computed tag kept for cross-checking against the encryption engine.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tag_o <= '0;
    end else if (load) begin
      tag_o <= '0;
    end else if (check) begin
      tag_o <= tag_calc;
    end
  end
`endif

endmodule

// File: doc/ascon_decrypt.md
Name: ascon_decrypt

Overview:
- ASCON-128a authenticated decryption engine, one round per cycle. It is the receive-side counterpart of the encryption datapath.
- Sequence: initialisation, one associated-data block, a stream of 128-bit ciphertext blocks, then finalisation.
- Outputs: one plaintext block per ciphertext block, plus a tag-match verdict.
- Contains its own 320-bit state register, FSM and round counter. Reuses the existing round primitives (constante_add, substitution, diffusion).

Parameters:
- NB_ROUNDS_A, 12, rounds for initialisation and finalisation (round_i 0..11).
- NB_ROUNDS_B, 8, rounds per AD/data block (round_i 4..11).
- IV_G, 64'h80800C0800000000, ASCON-128a initial word S0.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a decryption; sampled only in IDLE.
- key_i  in  128  key; held stable from start to done.
- nonce_i  in  128  nonce; sampled at start.
- ad_i  in  128  single associated-data block, already padded by the caller; held until AD phase ends.
- cipher_valid_i  in  1  ciphertext block valid.
- cipher_i  in  128  ciphertext block (full 128 bits).
- cipher_last_i  in  1  marks final ciphertext block; qualified by handshake.
- cipher_ready_o  out  1  engine can accept a block.
- tag_i  in  128  received tag; held stable until done_o.
- plain_valid_o  out  1  one-cycle pulse, plain_o valid.
- plain_o  out  128  decrypted block.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of finalisation.
- tag_ok_o  out  1  tag verdict, valid with done_o and held until next start.

Behaviour:
- Reset (asynchronous, active-high, any state): FSM goes to IDLE; state register, round counter, plain_o, tag_ok_o all cleared to 0. All outputs are 0 during and after reset.
- FSM states: IDLE, INIT, AD, WAIT_C, DATA, FINAL, DONE.
- IDLE:
  - start_i=1 loads S = {IV_G, key_i[127:64], key_i[63:0], nonce_i[127:64], nonce_i[63:0]}, counter=0, then goes to INIT.
  - start_i in any other state is ignored.
- INIT (12 cycles): one permutation round per cycle, round_i = counter.
  - Last round output is XORed with key into S3||S4.
  - Then S0||S1 ^= ad_i is applied at AD entry (folded into the first AD cycle input).
- AD (8 cycles): round_i = 4..11. Last round output gets S4 ^= 64'h1 (domain separation). Then goes to WAIT_C.
- WAIT_C: cipher_ready_o=1; no rounds run. On handshake (cipher_valid_i & cipher_ready_o):
  - plain_o <= cipher_i ^ {S0,S1}.
  - {S0,S1} <= cipher_i (replacement, not XOR).
  - last flag latched from cipher_last_i; goes to DATA.
  - plain_valid_o is high the cycle after the handshake, for exactly one cycle.
  - Without valid, the FSM waits indefinitely and S is unchanged.
- DATA (8 cycles): round_i = 4..11.
  - If latched last=0, return to WAIT_C.
  - If last=1, go to FINAL; on entry apply S0 ^= 64'h8000000000000000 (empty pad block) and S2||S3 ^= key_i.
- FINAL (12 cycles): round_i = 0..11. Computed tag T = {S3,S4} ^ key_i from the last round output.
  - tag_ok_o <= (T == tag_i); then goes to DONE.
- DONE (1 cycle): done_o=1, then returns to IDLE.
- Plaintext is always released; tag_ok_o=0 is the caller's signal to discard it.
- cipher_ready_o is 0 in all states other than WAIT_C; data offered at those times is not consumed.
- Latency:
  - start edge to first cipher_ready_o high: 21 cycles.
  - Each block occupies 9 cycles (handshake + 8 rounds).
  - DATA-last end to done_o: 13 cycles.
- Round counter: 4-bit, saturates at the phase end value; reset to phase start on every transition.

Optional Feature:
- Macro ASCON_DEC_TAG_OUT_EN.
- Defined: adds output port tag_o[127:0] holding computed T. It is registered in FINAL's last cycle, reset 0, and held until the next start; intended for debug and cross-check against the encryption engine.
- Undefined: port absent; T exists only inside the comparator.

Decomposition:
- ascon_pack (shared package) holds: type_state (5x64), IV_G value, pad constant 64'h8000000000000000, the FSM state enum type_dec_state, and the NB_ROUNDS_* constants.
- Natural sub-module: fsm_decrypt.
  - Owns state enum and round counter.
  - Drives round_i, mux/xor/replace selects, cipher_ready_o, plain_valid_o, done_o, busy_o.
- The top level holds the datapath: round primitives, state register, plain_o and tag registers, comparator.

Test Plan:
- Reset: assert reset_i mid-INIT -> all outputs 0 immediately. After release, busy_o=0 until next start_i.
- Round-trip, key=000102..0F, nonce=000102..0F, ad=padded 0x00010203 block: encrypt two 128-bit blocks with the existing encryption block, feed C and tag -> plain_o equals the original PT on both pulses; cipher_ready_o first high 21 cycles after start; done_o 13 cycles after last DATA; tag_ok_o=1.
- Same vectors with tag_i bit 0 flipped -> identical plain_o, tag_ok_o=0 with done_o.
- Stall: hold cipher_valid_i=0 for 5 cycles in WAIT_C -> cipher_ready_o stays 1, no plain_valid_o, state unchanged; result identical to the unstalled run.
- start_i pulsed during DATA -> ignored, run completes with correct tag_ok_o=1.
- Reset asserted during DATA of block 2, then a fresh start with the first vectors -> correct plaintext and tag_ok_o=1.
